ycbcr2rgb_block_converter: RTL and testbench

Sequential 64-pixel YCbCr-to-RGB block converter for the decode path. It accepts one 8x8 block of fixed-point Y/Cb/Cr samples, the format produced by the forward colour converter. It returns the 8-bit R/G/B block after rounding and clamping. Conversion is time-multiplexed over LANES pixel converters through a 2-stage pipeline, with valid/ready handshakes on both sides.

---
 rtl/ycbcr2rgb_block_converter.sv | 199 +++++++++++++++++++
 tb/tb_ycbcr2rgb_block_converter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb_block_converter.sv
// Sequential 8x8 YCbCr-to-RGB block converter: LANES pixels per beat through a
// two-stage multiply / sum-round-clamp pipeline, valid/ready on both sides.
`timescale 1ns/1ps
module ycbcr2rgb_block_converter #(
    parameter int fixed_point_length = 32,
    parameter int FRAC_BITS          = 16,
    parameter int LANES              = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [fixed_point_length*64-1:0] y_all,
    input  logic [fixed_point_length*64-1:0] cb_all,
    input  logic [fixed_point_length*64-1:0] cr_all,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [8*64-1:0]                  r_all,
    output logic [8*64-1:0]                  g_all,
    output logic [8*64-1:0]                  b_all,
    output logic                             out_valid,
    input  logic                             out_ready
);
    localparam int W  = fixed_point_length;
    localparam int N  = 64 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = W + 1;
    localparam int PW = DW + 18;
    localparam int SW = PW + 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    localparam logic signed [PW-1:0] K_R  = PW'(18'sd91881);
    localparam logic signed [PW-1:0] K_GB = PW'(18'sd22554);
    localparam logic signed [PW-1:0] K_GR = PW'(18'sd46802);
    localparam logic signed [PW-1:0] K_B  = PW'(18'sd116130);
    localparam logic signed [DW-1:0] OFFSET = DW'(9'd128) << FRAC_BITS;

    logic [1:0]          state_r;
    logic [CW-1:0]       cnt_r;
    logic [W*64-1:0]     y_r, cb_r, cr_r;
    logic                s1_valid_r;
    logic [CW-1:0]       s1_beat_r;
    logic [W-1:0]        y1_r   [LANES];
    logic signed [PW-1:0] t_r_r  [LANES];
    logic signed [PW-1:0] t_gb_r [LANES];
    logic signed [PW-1:0] t_gr_r [LANES];
    logic signed [PW-1:0] t_b_r  [LANES];
    logic [8*64-1:0]     r_r, g_r, b_r;
    logic                out_valid_r;

    logic [W-1:0]         y_s   [LANES];
    logic signed [DW-1:0] dcb_s [LANES];
    logic signed [DW-1:0] dcr_s [LANES];
    logic [7:0]           rp_s  [LANES];
    logic [7:0]           gp_s  [LANES];
    logic [7:0]           bp_s  [LANES];

    // Q.16 constant product, arithmetic shift keeps the sign of the chroma offset
    function automatic logic signed [PW-1:0] scale(input logic signed [DW-1:0] d,
                                                   input logic signed [PW-1:0] k);
        logic signed [PW-1:0] p;
        p = PW'(d) * k;
        return p >>> 16;
    endfunction

    function automatic logic [7:0] round_clamp(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] half;
        logic signed [SW-1:0] rnd;
        half = '0;
        half[FRAC_BITS-1] = 1'b1;
        rnd = (s + half) >>> FRAC_BITS;
        if (rnd < 0) begin
            return 8'd0;
        end else if (rnd > 255) begin
            return 8'd255;
        end else begin
            return rnd[7:0];
        end
    endfunction

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign r_all     = r_r;
    assign g_all     = g_r;
    assign b_all     = b_r;

    // Select this beat's pixels and remove the chroma offset
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            y_s[l]   = y_r[(int'(cnt_r) * LANES + l) * W +: W];
            dcb_s[l] = $signed({1'b0, cb_r[(int'(cnt_r) * LANES + l) * W +: W]}) - OFFSET;
            dcr_s[l] = $signed({1'b0, cr_r[(int'(cnt_r) * LANES + l) * W +: W]}) - OFFSET;
        end
    end

    // Stage-2 sums followed by rounding and clamping to 8 bits
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            rp_s[l] = round_clamp($signed({{(SW-W){1'b0}}, y1_r[l]}) + SW'(t_r_r[l]));
            gp_s[l] = round_clamp($signed({{(SW-W){1'b0}}, y1_r[l]}) - SW'(t_gb_r[l])
                                  - SW'(t_gr_r[l]));
            bp_s[l] = round_clamp($signed({{(SW-W){1'b0}}, y1_r[l]}) + SW'(t_b_r[l]));
        end
    end

    // Control FSM, beat counter and input block capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            y_r         <= '0;
            cb_r        <= '0;
            cr_r        <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        y_r     <= y_all;
                        cb_r    <= cb_all;
                        cr_r    <= cr_all;
                        cnt_r   <= '0;
                        state_r <= CONVERT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CONVERT: begin
                    if (cnt_r == CW'(N - 1)) begin
                        cnt_r   <= '0;
                        state_r <= DRAIN;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                DRAIN: begin
                    out_valid_r <= 1'b1;
                    state_r     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= HOLD;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Stage 1: register Y and the four scaled chroma products for the current beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_beat_r  <= '0;
            for (int l = 0; l < LANES; l++) begin
                y1_r[l]   <= '0;
                t_r_r[l]  <= '0;
                t_gb_r[l] <= '0;
                t_gr_r[l] <= '0;
                t_b_r[l]  <= '0;
            end
        end else begin
            s1_valid_r <= (state_r == CONVERT);
            s1_beat_r  <= cnt_r;
            if (state_r == CONVERT) begin
                for (int l = 0; l < LANES; l++) begin
                    y1_r[l]   <= y_s[l];
                    t_r_r[l]  <= scale(dcr_s[l], K_R);
                    t_gb_r[l] <= scale(dcb_s[l], K_GB);
                    t_gr_r[l] <= scale(dcr_s[l], K_GR);
                    t_b_r[l]  <= scale(dcb_s[l], K_B);
                end
            end
        end
    end

    // Stage 2: write the finished pixels of the beat into the output block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r <= '0;
            g_r <= '0;
            b_r <= '0;
        end else if (s1_valid_r) begin
            for (int l = 0; l < LANES; l++) begin
                r_r[(int'(s1_beat_r) * LANES + l) * 8 +: 8] <= rp_s[l];
                g_r[(int'(s1_beat_r) * LANES + l) * 8 +: 8] <= gp_s[l];
                b_r[(int'(s1_beat_r) * LANES + l) * 8 +: 8] <= bp_s[l];
            end
        end
    end
endmodule

// File: tb/tb_ycbcr2rgb_block_converter.sv
// Bench for ycbcr2rgb_block_converter: constant-colour table, ordering/rounding,
// random blocks against an arithmetic model, backpressure and mid-block reset.
`timescale 1ns/1ps
module tb_ycbcr2rgb_block_converter;
    localparam int W = 32;
    typedef logic [W*64-1:0] bus_t;
    typedef logic [8*64-1:0] pix_t;

    typedef struct {
        logic [31:0] y, cb, cr;
        logic [7:0]  er, eg, eb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bus_t y_all, cb_all, cr_all;
    logic in_valid, in_ready, out_valid, out_ready;
    pix_t r_all, g_all, b_all;

    int n_vec = 0;
    int n_bad = 0;

    ycbcr2rgb_block_converter dut (
        .clk(clk), .rst_n(rst_n),
        .y_all(y_all), .cb_all(cb_all), .cr_all(cr_all),
        .in_valid(in_valid), .in_ready(in_ready),
        .r_all(r_all), .g_all(g_all), .b_all(b_all),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference: real-valued colour equations carried out in 64-bit integers
    function automatic logic [7:0] ref_px(input longint y, input longint cb,
                                          input longint cr, input int ch);
        longint dcb, dcr, s;
        dcb = cb - (longint'(128) * 65536);
        dcr = cr - (longint'(128) * 65536);
        if (ch == 0)      s = y + ((dcr * 91881) >>> 16);
        else if (ch == 1) s = y - ((dcb * 22554) >>> 16) - ((dcr * 46802) >>> 16);
        else              s = y + ((dcb * 116130) >>> 16);
        s = (s + 32768) >>> 16;
        if (s < 0)   return 8'd0;
        if (s > 255) return 8'd255;
        return s[7:0];
    endfunction

    function automatic bus_t rnd_bus(input bit narrow);
        bus_t b;
        for (int i = 0; i < 64; i++)
            b[i*W +: W] = narrow ? ($urandom & 32'h00FF_FFFF) : $urandom;
        return b;
    endfunction

    task automatic check_expected(input string name, input pix_t er, input pix_t eg,
                                  input pix_t eb);
        pix_t got [3];
        pix_t exp [3];
        got[0] = r_all; got[1] = g_all; got[2] = b_all;
        exp[0] = er;    exp[1] = eg;    exp[2] = eb;
        n_vec++;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 64; i++) begin
                if (got[c][i*8 +: 8] !== exp[c][i*8 +: 8]) begin
                    n_bad++;
                    $display("FAIL %s pixel %0d chan %0d: got %0d, expected %0d",
                             name, i, c, got[c][i*8 +: 8], exp[c][i*8 +: 8]);
                    return;
                end
            end
        end
    endtask

    task automatic check_model(input string name, input bus_t y, input bus_t cb, input bus_t cr);
        pix_t er, eg, eb;
        for (int i = 0; i < 64; i++) begin
            er[i*8 +: 8] = ref_px(longint'(y[i*W +: W]), longint'(cb[i*W +: W]),
                                  longint'(cr[i*W +: W]), 0);
            eg[i*8 +: 8] = ref_px(longint'(y[i*W +: W]), longint'(cb[i*W +: W]),
                                  longint'(cr[i*W +: W]), 1);
            eb[i*8 +: 8] = ref_px(longint'(y[i*W +: W]), longint'(cb[i*W +: W]),
                                  longint'(cr[i*W +: W]), 2);
        end
        check_expected(name, er, eg, eb);
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    // Present a block and return #1 after its acceptance edge with the buses scrambled
    task automatic send_block(input bus_t y, input bus_t cb, input bus_t cr);
        int t;
        @(negedge clk);
        y_all = y; cb_all = cb; cr_all = cr; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++; n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        y_all = rnd_bus(1'b0); cb_all = rnd_bus(1'b0); cr_all = rnd_bus(1'b0);
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int lat;
        logic rdy_low;
        lat = 0;
        rdy_low = 1'b1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (in_ready) rdy_low = 1'b0;
            if (out_valid) break;
        end
        n_vec++;
        if (!out_valid || lat != exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d edges (out_valid=%b), expected %0d",
                     name, lat, out_valid, exp_lat);
        end
        check_bit({name, " in_ready low while busy"}, rdy_low, 1'b1);
    endtask

    task automatic finish_hs(input string name);
        @(posedge clk);
        #1;
        check_bit({name, " in_ready after handshake"}, in_ready, 1'b1);
        check_bit({name, " out_valid after handshake"}, out_valid, 1'b0);
    endtask

    vec_t tbl [6];
    bus_t ya, cba, cra, yb, cbb, crb;
    pix_t er, eg, eb, sr, sg, sb;
    logic stable;

    initial begin
        in_valid = 1'b0; out_ready = 1'b1;
        y_all = '0; cb_all = '0; cr_all = '0;

        tbl[0] = '{32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 8'd128, 8'd128, 8'd128};
        tbl[1] = '{32'h0000_0000, 32'h0080_0000, 32'h00FF_0000, 8'd178, 8'd0,   8'd0};
        tbl[2] = '{32'h00FF_0000, 32'h00FF_0000, 32'h00FF_0000, 8'd255, 8'd121, 8'd255};
        tbl[3] = '{32'h00FF_FFFF, 32'h0080_0000, 32'h0080_0000, 8'd255, 8'd255, 8'd255};
        tbl[4] = '{32'h0050_0000, 32'h00FF_0000, 32'h0080_0000, 8'd80,  8'd36,  8'd255};
        tbl[5] = '{32'h0080_0000, 32'h0000_0000, 32'h0000_0000, 8'd0,   8'd255, 8'd0};

        repeat (3) @(posedge clk);
        #1;
        check_bit("reset in_ready", in_ready, 1'b1);
        check_bit("reset out_valid", out_valid, 1'b0);
        check_expected("reset outputs", '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            send_block({64{tbl[v].y}}, {64{tbl[v].cb}}, {64{tbl[v].cr}});
            wait_valid($sformatf("table%0d", v), 9);
            check_expected($sformatf("table%0d", v), {64{tbl[v].er}}, {64{tbl[v].eg}},
                           {64{tbl[v].eb}});
            finish_hs($sformatf("table%0d", v));
        end

        for (int i = 0; i < 64; i++) begin
            ya[i*W +: W] = 32'(i) << 16;
            er[i*8 +: 8] = 8'(i);
        end
        ya[5*W +: W] = 32'h0064_8000; er[5*8 +: 8] = 8'd101;
        ya[6*W +: W] = 32'h0064_7FFF; er[6*8 +: 8] = 8'd100;
        send_block(ya, {64{32'h0080_0000}}, {64{32'h0080_0000}});
        wait_valid("ordering", 9);
        check_expected("ordering", er, er, er);
        finish_hs("ordering");

        for (int k = 0; k < 6; k++) begin
            ya = rnd_bus(k < 3); cba = rnd_bus(k < 3); cra = rnd_bus(k < 3);
            send_block(ya, cba, cra);
            wait_valid($sformatf("random%0d", k), 9);
            check_model($sformatf("random%0d", k), ya, cba, cra);
            finish_hs($sformatf("random%0d", k));
        end

        out_ready = 1'b0;
        ya = rnd_bus(1'b1); cba = rnd_bus(1'b1); cra = rnd_bus(1'b1);
        yb = rnd_bus(1'b1); cbb = rnd_bus(1'b1); crb = rnd_bus(1'b1);
        send_block(ya, cba, cra);
        wait_valid("bp first", 9);
        check_model("bp first", ya, cba, cra);
        sr = r_all; sg = g_all; sb = b_all;
        @(negedge clk);
        y_all = yb; cb_all = cbb; cr_all = crb; in_valid = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || r_all !== sr || g_all !== sg || b_all !== sb)
                stable = 1'b0;
        end
        check_bit("bp hold stable", stable, 1'b1);
        @(negedge clk);
        out_ready = 1'b1;
        finish_hs("bp release");
        send_block(yb, cbb, crb);
        wait_valid("bp second", 9);
        check_model("bp second", yb, cbb, crb);
        finish_hs("bp second");

        send_block({64{32'h0080_0000}}, {64{32'h0080_0000}}, {64{32'h0080_0000}});
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("midreset out_valid", out_valid, 1'b0);
        check_bit("midreset in_ready", in_ready, 1'b1);
        check_expected("midreset outputs", '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        send_block({64{32'h0080_0000}}, {64{32'h0080_0000}}, {64{32'h0080_0000}});
        wait_valid("post reset grey", 9);
        check_expected("post reset grey", {64{8'h80}}, {64{8'h80}}, {64{8'h80}});
        finish_hs("post reset grey");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
